// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - operand bus and status signals of the serial add sequencer
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             go;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] a_val;
  logic [WIDTH-1:0] b_val;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;
  logic [1:0]       phase;

  modport master (
    output go, din,
    input  a_val, b_val, sum, cout, busy, done, phase
  );

  modport slave (
    input  go, din,
    output a_val, b_val, sum, cout, busy, done, phase
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - captures A then B on button presses and adds them bit-serially, LSB first
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clock,
  input  logic              Resetn,
  serial_add_ctrl_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HAVE_A = 2'd1,
    S_ADD    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_go_q;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-2:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;

  logic             w_press;
  logic             w_last;
  logic             w_s;
  logic             w_carry;
  logic [WIDTH-1:0] w_acc_next;

  assign w_press    = bus.go & ~r_go_q;
  assign w_last     = (r_cnt == LAST);
  assign w_s        = r_sa[0] ^ r_sb[0] ^ r_c;
  assign w_carry    = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_c) | (r_sb[0] & r_c);
  // The accumulator keeps only the upper bits; the newest sum bit enters at the MSB.
  assign w_acc_next = {w_s, r_acc};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_press) w_next = S_HAVE_A;
      S_HAVE_A: if (w_press) w_next = S_ADD;
      S_ADD:    if (w_last)  w_next = S_DONE;
      S_DONE:   if (w_press) w_next = S_HAVE_A;
      default:  w_next = S_IDLE;
    endcase
  end

  // go_q resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
      r_go_q  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_go_q  <= bus.go;
      r_busy  <= (w_next == S_ADD);
      r_done  <= (r_state == S_ADD) && (w_next == S_DONE);
    end
  end

  always_ff @(posedge clock or negedge Resetn) begin
    if (!Resetn) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sa   <= '0;
      r_sb   <= '0;
      r_acc  <= '0;
      r_sum  <= '0;
      r_c    <= 1'b0;
      r_cout <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_press) r_a <= bus.din;
        end
        S_HAVE_A: begin
          if (w_press) begin
            r_b   <= bus.din;
            r_sa  <= r_a;
            r_sb  <= bus.din;
            r_c   <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_ADD: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_c   <= w_carry;
          r_acc <= w_acc_next[WIDTH-1:1];
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum  <= w_acc_next;
            r_cout <= w_carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.a_val = r_a;
  assign bus.b_val = r_b;
  assign bus.sum   = r_sum;
  assign bus.cout  = r_cout;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.phase = r_state;
endmodule
